mdu_ctrl: RTL and testbench

Multiply/divide sequencer for the E stage of the five-stage pipeline. Latches operands on a MULT/MULTU/DIV/DIVU issue, holds the unit busy for a fixed cycle count, then commits the result to HI/LO. Owns the HI/LO registers, serves MFHI/MFLO/MTHI/MTLO, and generates the D-stage stall that keeps MDU instructions out of E while the unit is occupied.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/mdu_arith.sv | 51 +++++
 rtl/mdu_ctrl.sv | 102 ++++++++++
 tb/tb_mdu_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM encoding and default latencies for the multiply/divide unit.
// Build option: define MDU_MADD_EN to accept opcode 9 (MADD).
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;

  localparam int unsigned DefaultMultCycles = 5;
  localparam int unsigned DefaultDivCycles  = 10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} mdu_state_e;

  function automatic logic is_calc(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_calc = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD: is_calc = 1'b1;
`else
      MDU_MADD: is_calc = 1'b0;
`endif
      MDU_NONE: is_calc = 1'b0;
      default:  is_calc = 1'b0;
    endcase
  endfunction

  // Selects the short (multiply-class) latency.
  function automatic logic is_mul(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD: is_mul = 1'b1;
`endif
      default: is_mul = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for a multiply/divide op.
// Build option: MDU_MADD_EN adds the signed multiply-accumulate path.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [63:0] hilo,
  output logic [63:0] result
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_ovf;
  logic        [31:0] div_rt_s;
  logic        [31:0] div_rt_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  always_comb begin
    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'b0, rs} * {32'b0, rt};

    // Dividing by 1 in the overflow case yields exactly q=0x80000000, r=0; a zero
    // divisor is also replaced so the dividers never see it.
    div_ovf  = (rs == 32'h8000_0000) && (rt == 32'hffff_ffff);
    div_rt_s = ((rt == 32'd0) || div_ovf) ? 32'd1 : rt;
    div_rt_u = (rt == 32'd0) ? 32'd1 : rt;

    quo_s = $signed(rs) / $signed(div_rt_s);
    rem_s = $signed(rs) % $signed(div_rt_s);
    quo_u = rs / div_rt_u;
    rem_u = rs % div_rt_u;

    result = '0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = (rt == 32'd0) ? hilo : {rem_s, quo_s};
      MDU_DIVU:  result = (rt == 32'd0) ? hilo : {rem_u, quo_u};
`ifdef MDU_MADD_EN
      MDU_MADD:  result = hilo + prod_s;
`endif
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, busy counter and the D-stage stall.
// Build option: MDU_MADD_EN enables the MADD opcode.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DefaultMultCycles,
  parameter int unsigned DIV_CYCLES  = DefaultDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_mdu_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_mdu_use,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  mdu_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [63:0]     pending_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic            busy_q;
  logic [63:0]     arith_result;

  mdu_arith u_arith (
    .op     (e_mdu_op),
    .rs     (e_rs),
    .rt     (e_rt),
    .hilo   ({hi_q, lo_q}),
    .result (arith_result)
  );

  always_comb begin
    start = is_calc(e_mdu_op);
    stall = d_mdu_use && (start || busy_q);
    case (e_mdu_op)
      MDU_MFHI: mf_data = hi_q;
      MDU_MFLO: mf_data = lo_q;
      default:  mf_data = '0;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pending_q <= arith_result;
            busy_q    <= 1'b1;
            if (is_mul(e_mdu_op)) begin
              state_q <= StMul;
              cnt_q   <= CntW'(MULT_CYCLES);
            end else begin
              state_q <= StDiv;
              cnt_q   <= CntW'(DIV_CYCLES);
            end
          end else if (e_mdu_op == MDU_MTHI) begin
            hi_q <= e_rs;
          end else if (e_mdu_op == MDU_MTLO) begin
            lo_q <= e_rs;
          end
        end
        // Any op arriving in E while busy is dropped; the stall normally prevents it.
        StMul, StDiv: begin
          if (cnt_q == CntW'(1)) begin
            {hi_q, lo_q} <= pending_q;
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized bench for mdu_ctrl against a cycle-level arithmetic model of HI/LO and busy.
module tb_mdu_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  e_mdu_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_mdu_use;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: architectural HI/LO, remaining busy cycles, result awaiting commit.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_rem;

  mdu_ctrl #(
    .MULT_CYCLES (MultN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .e_mdu_op  (e_mdu_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .d_mdu_use (d_mdu_use),
    .start     (start),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .mf_data   (mf_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_is_calc(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || op == 4'd9;
`else
    return op >= 4'd1 && op <= 4'd4;
`endif
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return acc;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      4'd9: return acc + sa * sb;
      default: return 64'd0;
    endcase
  endfunction

  // One E-stage cycle: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic duse);
    logic        exp_start;
    logic [31:0] exp_mf;
    e_mdu_op  = op;
    e_rs      = a;
    e_rt      = b;
    d_mdu_use = duse;
    @(negedge clk);
    exp_start = ref_is_calc(op);
    exp_mf    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    check_eq("start", start, exp_start);
    check_eq("busy", busy, m_rem > 0);
    check_eq("stall", stall, duse && (exp_start || m_rem > 0));
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
    check_eq("mf_data", mf_data, exp_mf);
    @(posedge clk);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) {m_hi, m_lo} = m_pend;
    end else if (exp_start) begin
      m_pend = ref_result(op, a, b, {m_hi, m_lo});
      m_rem  = (op == 4'd3 || op == 4'd4) ? int'(DivN) : int'(MultN);
    end else if (op == 4'd7) begin
      m_hi = a;
    end else if (op == 4'd8) begin
      m_lo = a;
    end
    #1;
  endtask

  task automatic run_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic duse);
    step(op, a, b, duse);
    for (int i = 0; i < int'(DivN) + 2 && m_rem > 0; i++) step(4'd0, 32'd0, 32'd0, duse);
  endtask

  initial begin
    m_hi = '0; m_lo = '0; m_pend = '0; m_rem = 0;
    reset = 1'b0; e_mdu_op = 4'd1; e_rs = 32'd7; e_rt = 32'd9; d_mdu_use = 1'b1;
    #2;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_start", start, 1'b1);
    check_eq("rst_stall", stall, 1'b1);
    e_mdu_op = 4'd0; d_mdu_use = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_calc(4'd1, 32'hffff_fffe, 32'd3, 1'b1);
    check_eq("mult_hi", hi, 32'hffff_ffff);
    check_eq("mult_lo", lo, 32'hffff_fffa);
    step(4'd6, 32'd0, 32'd0, 1'b0);
    run_calc(4'd2, 32'hffff_fffe, 32'd3, 1'b0);
    check_eq("multu_hi", hi, 32'h2);
    check_eq("multu_lo", lo, 32'hffff_fffa);
    run_calc(4'd3, 32'hffff_fff9, 32'd2, 1'b0);
    check_eq("div_hi", hi, 32'hffff_ffff);
    check_eq("div_lo", lo, 32'hffff_fffd);
    run_calc(4'd4, 32'd7, 32'd2, 1'b0);
    check_eq("divu_hi", hi, 32'd1);
    check_eq("divu_lo", lo, 32'd3);
    step(4'd7, 32'h11, 32'd0, 1'b0);
    step(4'd8, 32'h22, 32'd0, 1'b0);
    run_calc(4'd4, 32'd5, 32'd0, 1'b1);
    check_eq("div0_hi", hi, 32'h11);
    check_eq("div0_lo", lo, 32'h22);
    run_calc(4'd3, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    check_eq("ovf_hi", hi, 32'd0);
    check_eq("ovf_lo", lo, 32'h8000_0000);
    step(4'd7, 32'h1234, 32'd0, 1'b0);
    step(4'd5, 32'd0, 32'd0, 1'b1);
    check_eq("mthi_hi", hi, 32'h1234);

    step(4'd7, 32'd0, 32'd0, 1'b0);
    step(4'd8, 32'd10, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    run_calc(4'd9, 32'd3, 32'd4, 1'b0);
    check_eq("madd_lo", lo, 32'd22);
`else
    step(4'd9, 32'd3, 32'd4, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0);
    check_eq("madd_off_lo", lo, 32'd10);
`endif

    // Abort in the third busy cycle.
    step(4'd1, 32'd1000, 32'd1000, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_hi", hi, 32'd0);
    check_eq("abort_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0; m_pend = '0; m_rem = 0;
    e_mdu_op = 4'd0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hffff_ffff; end
      else if (sel == 2) b = 32'($urandom_range(1, 9));
      step(op, a, b, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < int'(DivN) + 2 && m_rem > 0; i++) step(4'd0, 32'd0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
